// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI serial-SRAM responder: opcodes, FSM state
// encodings, addressing modes and the opcode decoder.
package spi_ram_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_WRSR  = 8'h01;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_CMD    = 3'd1;
   localparam state_t ST_ADDR   = 3'd2;
   localparam state_t ST_RDATA  = 3'd3;
   localparam state_t ST_WDATA  = 3'd4;
   localparam state_t ST_RDSR   = 3'd5;
   localparam state_t ST_WRSR   = 3'd6;
   localparam state_t ST_IGNORE = 3'd7;

   // status[7:6] addressing modes; 2'b11 is reserved and behaves as sequential
   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_SEQ  = 2'b01;
   localparam logic [1:0] MODE_PAGE = 2'b10;

   // State entered after the opcode byte completes
   function automatic state_t decode_op(input logic [7:0] op);
      case (op)
         OP_READ, OP_WRITE: return ST_ADDR;
         OP_RDSR:           return ST_RDSR;
         OP_WRSR:           return ST_WRSR;
         default:           return ST_IGNORE;
      endcase
   endfunction

endpackage

// File: rtl/spi_ram_responder_sync.sv
// Oversampling front end: synchronizes SCK, nSS and MOSI into the system
// clock domain and produces single-cycle SCK rise/fall pulses.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sck_pin,
   input  logic nss_pin,
   input  logic mosi_pin,
   output logic sck_rise,
   output logic sck_fall,
   output logic nss_level,
   output logic mosi_level
);

   logic [SYNC_STAGES-1:0] sck_q;
   logic [SYNC_STAGES-1:0] nss_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   sck_prev;

   // Synchronizer chains plus one history flop on SCK for edge detection.
   // The nSS chain resets low so the controller never mistakes the reset
   // value for a real deselect; it arms only once the pin is seen high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q    <= '0;
         nss_q    <= '0;
         mosi_q   <= '0;
         sck_prev <= 1'b0;
      end else begin
         for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            sck_q[i]  <= sck_q[i-1];
            nss_q[i]  <= nss_q[i-1];
            mosi_q[i] <= mosi_q[i-1];
         end
         sck_q[0]  <= sck_pin;
         nss_q[0]  <= nss_pin;
         mosi_q[0] <= mosi_pin;
         sck_prev  <= sck_q[SYNC_STAGES-1];
      end
   end

   assign sck_rise   =  sck_q[SYNC_STAGES-1] & ~sck_prev;
   assign sck_fall   = ~sck_q[SYNC_STAGES-1] &  sck_prev;
   assign nss_level  =  nss_q[SYNC_STAGES-1];
   assign mosi_level =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 target emulating a 23LC1024-style serial SRAM backed by an
// internal byte array. Handles READ, WRITE, RDSR and WRSR with byte,
// page and sequential addressing.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | deselected; waits for nSS low
//   CMD       | shifting in the opcode byte
//   ADDR      | shifting in ADDR_BYTES address bytes, MSB first
//   RDATA     | streaming mem[addr] on MISO, reloading every 8 bits
//   WDATA     | each completed byte is written to mem[addr]
//   RDSR      | streaming the status register repeatedly
//   WRSR      | first completed byte sets status[7:6]; rest ignored
//   IGNORE    | unknown opcode; MISO released until deselect
module spi_ram_responder
   import spi_ram_pkg::*;
#(
   parameter int DEPTH_LOG2  = 8,
   parameter int ADDR_BYTES  = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic SCK,
   input  logic nSS,
   input  logic MOSI,
   output logic MISO,
   output logic MISO_OE,
   output logic BUSY
);

   localparam int             AW        = 8 * ADDR_BYTES;
   localparam int             DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0]     LAST_ADDR = 4'(ADDR_BYTES - 1);

   logic                  sck_rise;
   logic                  sck_fall;
   logic                  nss_s;
   logic                  mosi_s;

   state_t                state;
   logic                  armed;
   logic [2:0]            bit_cnt;
   logic [6:0]            shift_in;
   logic [7:0]            shift_out;
   logic [AW-1:0]         addr_sr;
   logic [3:0]            addr_cnt;
   logic [DEPTH_LOG2-1:0] addr;
   logic [DEPTH_LOG2-1:0] next_addr;
   logic [1:0]            status;
   logic                  rd_op;
   logic                  wrsr_done;
   logic                  wr_pending;
   logic [7:0]            wr_data;
   logic [7:0]            mem [DEPTH];

   logic [7:0]            byte_in;
   logic                  byte_done;
   logic                  abort;
   logic [AW-1:0]         addr_next_sr;
   logic [7:0]            load_byte;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (CLK),
      .rst        (RST),
      .sck_pin    (SCK),
      .nss_pin    (nSS),
      .mosi_pin   (MOSI),
      .sck_rise   (sck_rise),
      .sck_fall   (sck_fall),
      .nss_level  (nss_s),
      .mosi_level (mosi_s)
   );

   assign byte_in      = {shift_in, mosi_s};
   assign byte_done    = sck_rise && (bit_cnt == 3'd7);
   assign abort        = nss_s | ~armed;
   assign addr_next_sr = (addr_sr << 8) | AW'(byte_in);
   assign load_byte    = (state == ST_RDATA) ? mem[addr] : {status, 6'b0};
   assign BUSY         = armed & ~nss_s;

   // Post-byte address step according to the addressing mode
   always_comb begin
      next_addr = addr + DEPTH_LOG2'(1);
      case (status)
         MODE_BYTE: next_addr = addr;
         MODE_PAGE: next_addr = {addr[DEPTH_LOG2-1:5], addr[4:0] + 5'd1};
         default:   next_addr = addr + DEPTH_LOG2'(1);
      endcase
   end

   // Transaction FSM, shift registers and MISO driver; deselect wins over
   // any SCK edge seen in the same cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         armed      <= 1'b0;
         bit_cnt    <= 3'd0;
         shift_in   <= 7'd0;
         shift_out  <= 8'd0;
         addr_sr    <= '0;
         addr_cnt   <= 4'd0;
         addr       <= '0;
         status     <= MODE_SEQ;
         rd_op      <= 1'b0;
         wrsr_done  <= 1'b0;
         wr_pending <= 1'b0;
         wr_data    <= 8'd0;
         MISO       <= 1'b0;
         MISO_OE    <= 1'b0;
      end else begin
         wr_pending <= 1'b0;
         if (nss_s)
            armed <= 1'b1;
         // the address steps in the same cycle the completed byte lands in mem
         if (wr_pending)
            addr <= next_addr;

         if (abort) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            addr_cnt  <= 4'd0;
            wrsr_done <= 1'b0;
            MISO_OE   <= 1'b0;
         end else if (state == ST_IDLE) begin
            state   <= ST_CMD;
            bit_cnt <= 3'd0;
         end else begin
            if (sck_rise) begin
               shift_in <= byte_in[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
               case (state)
                  ST_CMD: begin
                     rd_op    <= (byte_in == OP_READ);
                     addr_cnt <= 4'd0;
                     state    <= decode_op(byte_in);
                  end
                  ST_ADDR: begin
                     addr_sr  <= addr_next_sr;
                     addr_cnt <= addr_cnt + 4'd1;
                     if (addr_cnt == LAST_ADDR) begin
                        addr  <= addr_next_sr[DEPTH_LOG2-1:0];
                        state <= rd_op ? ST_RDATA : ST_WDATA;
                     end
                  end
                  ST_RDATA: addr <= next_addr;
                  ST_WDATA: begin
                     wr_pending <= 1'b1;
                     wr_data    <= byte_in;
                  end
                  ST_WRSR: begin
                     if (!wrsr_done) begin
                        status    <= byte_in[7:6];
                        wrsr_done <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end

            // a fall at a byte boundary loads the next byte and drives its MSB
            if (sck_fall && (state == ST_RDATA || state == ST_RDSR)) begin
               if (bit_cnt == 3'd0) begin
                  MISO      <= load_byte[7];
                  shift_out <= {load_byte[6:0], 1'b0};
                  MISO_OE   <= 1'b1;
               end else begin
                  MISO      <= shift_out[7];
                  shift_out <= {shift_out[6:0], 1'b0};
               end
            end
         end
      end
   end

   // Byte array write port; contents survive reset
   always_ff @(posedge CLK) begin
      if (wr_pending)
         mem[addr] <= wr_data;
   end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: a table of write/read transactions
// followed by hand-written status, byte/page mode, abort, unknown-opcode
// and reset-mid-read sequences.
module tb_spi_ram_responder;
   import spi_ram_pkg::*;

   localparam int HALF = 8;

   logic CLK = 1'b0;
   logic RST;
   logic SCK;
   logic nSS;
   logic MOSI;
   logic MISO;
   logic MISO_OE;
   logic BUSY;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_read;
      logic [23:0] addr;
      int          n;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[9];

   spi_ram_responder dut (
      .CLK     (CLK),
      .RST     (RST),
      .SCK     (SCK),
      .nSS     (nSS),
      .MOSI    (MOSI),
      .MISO    (MISO),
      .MISO_OE (MISO_OE),
      .BUSY    (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic bit_clock(input logic mosi_bit, output logic miso_bit, output logic oe_bit);
      MOSI = mosi_bit;
      repeat (HALF) @(negedge CLK);
      miso_bit = MISO;
      oe_bit   = MISO_OE;
      SCK      = 1'b1;
      repeat (HALF) @(negedge CLK);
      SCK = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
      logic m, o;
      for (int i = 7; i >= 0; i--) begin
         bit_clock(tx[i], m, o);
         rx[i] = m;
         oe[i] = o;
      end
   endtask

   task automatic select_dev();
      nSS = 1'b0;
      repeat (HALF) @(negedge CLK);
   endtask

   task automatic deselect_dev();
      repeat (HALF) @(negedge CLK);
      nSS = 1'b1;
      repeat (2 * HALF) @(negedge CLK);
   endtask

   task automatic header(input logic [7:0] op, input logic [23:0] a, output logic [7:0] oe_acc);
      logic [7:0] rx, oe;
      xfer(op, rx, oe);      oe_acc = oe;
      xfer(a[23:16], rx, oe); oe_acc |= oe;
      xfer(a[15:8], rx, oe);  oe_acc |= oe;
      xfer(a[7:0], rx, oe);   oe_acc |= oe;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [7:0] hdr_oe, tx, rx, oe, exp;
      select_dev();
      header(v.is_read ? OP_READ : OP_WRITE, v.addr, hdr_oe);
      check8({tag, " hdr_oe"}, hdr_oe, 8'h00);
      for (int b = 0; b < v.n; b++) begin
         exp = v.data[31 - 8*b -: 8];
         tx  = v.is_read ? 8'h00 : exp;
         xfer(tx, rx, oe);
         if (v.is_read) begin
            check8($sformatf("%s rd%0d", tag, b), rx, exp);
            check8($sformatf("%s oe%0d", tag, b), oe, 8'hFF);
         end else begin
            check8($sformatf("%s wr_oe%0d", tag, b), oe, 8'h00);
         end
      end
      deselect_dev();
   endtask

   task automatic wrsr(input logic [7:0] v0, input logic [7:0] v1);
      logic [7:0] rx, oe;
      select_dev();
      xfer(OP_WRSR, rx, oe);
      xfer(v0, rx, oe);
      xfer(v1, rx, oe);
      check8("wrsr_oe", oe, 8'h00);
      deselect_dev();
   endtask

   task automatic rdsr(input logic [7:0] exp, input string tag);
      logic [7:0] rx, oe;
      select_dev();
      xfer(OP_RDSR, rx, oe);
      check8({tag, " cmd_oe"}, oe, 8'h00);
      for (int k = 0; k < 2; k++) begin
         xfer(8'h00, rx, oe);
         check8($sformatf("%s sr%0d", tag, k), rx, exp);
         check8($sformatf("%s sr_oe%0d", tag, k), oe, 8'hFF);
      end
      deselect_dev();
   endtask

   initial begin
      logic [7:0] rx, oe, hdr_oe;
      logic       m, o;

      vecs[0] = '{1'b0, 24'h000010, 2, 32'hAA550000};
      vecs[1] = '{1'b1, 24'h000010, 2, 32'hAA550000};
      vecs[2] = '{1'b0, 24'h0000FF, 2, 32'h11220000};
      vecs[3] = '{1'b1, 24'h0000FF, 2, 32'h11220000};
      vecs[4] = '{1'b1, 24'h000000, 1, 32'h22000000};
      vecs[5] = '{1'b0, 24'h000005, 4, 32'h5A6B7C8D};
      vecs[6] = '{1'b0, 24'h000020, 1, 32'h3C000000};
      vecs[7] = '{1'b0, 24'h123401, 1, 32'hE7000000};
      vecs[8] = '{1'b1, 24'hFFFF00, 2, 32'h22E70000};

      RST = 1'b1; SCK = 1'b0; nSS = 1'b1; MOSI = 1'b0;
      repeat (3) @(negedge CLK);
      check8("rst_miso", {7'd0, MISO}, 8'h00);
      check8("rst_oe",   {7'd0, MISO_OE}, 8'h00);
      check8("rst_busy", {7'd0, BUSY}, 8'h00);
      RST = 1'b0;
      repeat (6) @(negedge CLK);

      rdsr(8'h40, "rdsr_reset");

      for (int i = 0; i < 9; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // byte mode: repeated writes land on one location
      wrsr(8'h00, 8'hC0);
      rdsr(8'h00, "rdsr_byte");
      run_vec('{1'b0, 24'h000005, 3, 32'h01020300}, "byte_wr");
      run_vec('{1'b1, 24'h000005, 2, 32'h03030000}, "byte_rd");

      // page mode: 0x1F wraps to 0x00 within the page; low status bits read 0
      wrsr(8'h9F, 8'h00);
      rdsr(8'h80, "rdsr_page");
      run_vec('{1'b0, 24'h00001F, 2, 32'h77880000}, "page_wr");
      wrsr(8'h41, 8'h00);
      rdsr(8'h40, "rdsr_seq");
      run_vec('{1'b1, 24'h000005, 2, 32'h036B0000}, "seq_rd5");
      run_vec('{1'b1, 24'h00001F, 2, 32'h773C0000}, "seq_rd1f");
      run_vec('{1'b1, 24'h000000, 1, 32'h88000000}, "seq_rd0");

      // abort after 5 data bits of a write to 0x20
      select_dev();
      header(OP_WRITE, 24'h000020, hdr_oe);
      for (int i = 7; i >= 3; i--) begin
         logic [7:0] c3;
         c3 = 8'hC3;
         bit_clock(c3[i], m, o);
      end
      deselect_dev();
      run_vec('{1'b1, 24'h000020, 1, 32'h3C000000}, "abort_rd");

      // unknown opcode keeps MISO released
      select_dev();
      xfer(8'h9F, rx, oe);
      check8("ign_busy", {7'd0, BUSY}, 8'h01);
      for (int k = 0; k < 3; k++) begin
         xfer(8'hFF, rx, oe);
         check8($sformatf("ign_oe%0d", k), oe, 8'h00);
      end
      deselect_dev();
      check8("ign_busy_end", {7'd0, BUSY}, 8'h00);
      run_vec('{1'b1, 24'h000010, 1, 32'hAA000000}, "after_ign");

      // reset during the third data bit of a read
      wrsr(8'h00, 8'h00);
      select_dev();
      header(OP_READ, 24'h000010, hdr_oe);
      bit_clock(1'b0, m, o);
      rx[7] = m;
      bit_clock(1'b0, m, o);
      rx[6] = m;
      check8("rstrd_bits", {6'd0, rx[7:6]}, 8'h02);
      MOSI = 1'b0;
      repeat (HALF) @(negedge CLK);
      SCK = 1'b1;
      @(negedge CLK);
      check8("rstrd_oe_pre", {7'd0, MISO_OE}, 8'h01);
      RST = 1'b1;
      #1;
      check8("rstrd_oe", {7'd0, MISO_OE}, 8'h00);
      check8("rstrd_busy", {7'd0, BUSY}, 8'h00);
      repeat (3) @(negedge CLK);
      SCK = 1'b0;
      nSS = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      rdsr(8'h40, "rdsr_after_rst");
      run_vec('{1'b1, 24'h000010, 2, 32'hAA550000}, "rd_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
